// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-port to async SRAM controller.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ACC   = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } sram_state_t;

    // Pin order {CE, UB, LB, OE, WE}, all active-low.
    localparam logic [4:0] SRAM_IDLE_CTL = 5'b11111;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module sram_wait_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Sequences a one-cycle CPU memory request into a timed async SRAM read or write,
// answering with a one-cycle ready pulse; all pins decode from registered state.
module sram_ctrl #(
    parameter int WAIT_CYC = 2,
    parameter int WR_PULSE = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  be,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    output logic [2:0]  dbg_state_o
);
    import slc3_mem_pkg::*;

    localparam int MAX_CYC = max_int(WAIT_CYC, WR_PULSE);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    generate
        if (WAIT_CYC < 1 || WR_PULSE < 1) begin : g_bad_param
            $error("sram_ctrl: WAIT_CYC and WR_PULSE must both be >= 1");
        end
    endgenerate

    sram_state_t state_q, state_d;
    logic        we_q;
    logic [1:0]  be_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q, rdata_d;

    logic             t_load, t_dec, t_zero;
    logic [CNT_W-1:0] t_val;
    logic [4:0]       ctl;
    logic             drive;

    sram_wait_timer #(.W(CNT_W)) u_timer (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (t_load),
        .load_val_i (t_val),
        .dec_i      (t_dec),
        .zero_o     (t_zero)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && req) begin
                we_q    <= we;
                be_q    <= be;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // The read counter is loaded on acceptance; the write counter on entry to the pulse.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_val   = CNT_W'(WAIT_CYC - 1);
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_ACC;
                        t_load  = 1'b1;
                    end
                end
            end
            RD_ACC: begin
                if (t_zero) begin
                    rdata_d = Data;
                    state_d = DONE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            WR_SETUP: begin
                t_load  = 1'b1;
                t_val   = CNT_W'(WR_PULSE - 1);
                state_d = slc3_mem_pkg::WR_PULSE;
            end
            slc3_mem_pkg::WR_PULSE: begin
                if (t_zero) begin
                    state_d = WR_HOLD;
                end else begin
                    t_dec = 1'b1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctl   = SRAM_IDLE_CTL;
        drive = 1'b0;
        case (state_q)
            RD_ACC:                  ctl = {1'b0, ~be_q, 1'b0, 1'b1};
            WR_SETUP, WR_HOLD: begin
                ctl   = {1'b0, ~be_q, 1'b1, 1'b1};
                drive = 1'b1;
            end
            slc3_mem_pkg::WR_PULSE: begin
                ctl   = {1'b0, ~be_q, 1'b1, 1'b0};
                drive = 1'b1;
            end
            default: ctl = SRAM_IDLE_CTL;
        endcase
    end

    assign {CE, UB, LB, OE, WE} = ctl;
    assign ready       = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign ADDR        = {4'b0000, addr_q};
    assign rdata       = rdata_q;
    assign Data        = drive ? wdata_q : 16'hzzzz;
    assign dbg_state_o = state_q;

    logic unused_we_q;
    assign unused_we_q = we_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl against a behavioural async SRAM (WAIT_CYC=2, WR_PULSE=2).
module tb_sram_ctrl;
    import slc3_mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        ready, busy;
    logic        ce_n, ub_n, lb_n, oe_n, we_n;
    logic [19:0] sram_addr;
    wire  [15:0] sram_data;
    logic [2:0]  dbg_state;

    int err_cnt = 0;
    int chk_cnt = 0;

    sram_ctrl #(.WAIT_CYC(2), .WR_PULSE(2)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req         (req),
        .we          (wr),
        .be          (be),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .busy        (busy),
        .CE          (ce_n),
        .UB          (ub_n),
        .LB          (lb_n),
        .OE          (oe_n),
        .WE          (we_n),
        .ADDR        (sram_addr),
        .Data        (sram_data),
        .dbg_state_o (dbg_state)
    );

    always #5 Clk = ~Clk;

    // Behavioural SRAM: drives on read, writes enabled byte lanes while CE and WE are low.
    logic [15:0] mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = 16'h0000;
    logic [15:0] pre_data = 16'h0000;

    assign sram_data = (!ce_n && !oe_n && we_n) ? mem[sram_addr[15:0]] : 16'hzzzz;

    always @(negedge Clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[15:0]][7:0]  <= sram_data[7:0];
            if (!ub_n) mem[sram_addr[15:0]][15:8] <= sram_data[15:8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge Clk);
        #1;
        pre_en = 1'b0;
    endtask

    // One access, then 8 observed cycles; bit k of each vector is cycle k+1.
    task automatic access(input logic w, input logic [1:0] b, input logic [15:0] a,
                          input logic [15:0] d, input bit spam,
                          output logic [7:0] ce_v, output logic [7:0] oe_v,
                          output logic [7:0] we_v, output logic [7:0] drv_v,
                          output logic [7:0] rdy_v, output logic [7:0] busy_v,
                          output logic [7:0] ub_v, output logic [7:0] lb_v,
                          output logic [19:0] a1);
        @(posedge Clk); #1;
        req = 1'b1; wr = w; be = b; addr = a; wdata = d;
        @(posedge Clk); #1;
        a1 = 20'h0;
        for (int k = 0; k < 8; k++) begin
            if (spam && k < 4) begin
                req = 1'b1; wr = 1'b1; be = 2'b11; addr = 16'h0500; wdata = 16'hDEAD;
            end else begin
                req = 1'b0;
            end
            @(negedge Clk);
            ce_v[k]   = ~ce_n;
            oe_v[k]   = ~oe_n;
            we_v[k]   = ~we_n;
            ub_v[k]   = ~ub_n;
            lb_v[k]   = ~lb_n;
            drv_v[k]  = oe_n && (sram_data === d);
            rdy_v[k]  = ready;
            busy_v[k] = busy;
            if (k == 0) a1 = sram_addr;
            @(posedge Clk); #1;
        end
    endtask

    logic [7:0]  ce_v, oe_v, we_v, drv_v, rdy_v, busy_v, ub_v, lb_v;
    logic [19:0] a1;
    logic [11:0] busy12, rdy12;
    int          overlap, rdy_seen;

    initial begin
        #3;
        check("rst_pins",  {27'h0, ce_n, ub_n, lb_n, oe_n, we_n}, {27'h0, SRAM_IDLE_CTL});
        check("rst_data_z", {31'h0, (sram_data === 16'hzzzz)}, 32'h1);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_rdata", {16'h0, rdata}, 32'h0);
        check("rst_addr",  {12'h0, sram_addr}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, {29'h0, IDLE});
        preload(16'h1234, 16'hBEEF);
        preload(16'h00FF, 16'h0000);
        preload(16'h0300, 16'hFFFF);
        preload(16'h0400, 16'h0000);
        preload(16'h0500, 16'h0000);
        preload(16'h0600, 16'h0000);
        preload(16'h0700, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;

        // Read with two wait states
        access(1'b0, 2'b11, 16'h1234, 16'h0000, 0, ce_v, oe_v, we_v, drv_v, rdy_v, busy_v, ub_v, lb_v, a1);
        check("t1_oe",    {24'h0, oe_v},   32'h03);
        check("t1_ce",    {24'h0, ce_v},   32'h03);
        check("t1_we",    {24'h0, we_v},   32'h00);
        check("t1_ready", {24'h0, rdy_v},  32'h04);
        check("t1_busy",  {24'h0, busy_v}, 32'h07);
        check("t1_addr",  {12'h0, a1},     32'h01234);
        check("t1_rdata", {16'h0, rdata},  32'hBEEF);

        // Full-word write, then read-back
        access(1'b1, 2'b11, 16'h00FF, 16'hA5A5, 0, ce_v, oe_v, we_v, drv_v, rdy_v, busy_v, ub_v, lb_v, a1);
        check("t2_drive", {24'h0, drv_v},  32'h0F);
        check("t2_we",    {24'h0, we_v},   32'h06);
        check("t2_oe",    {24'h0, oe_v},   32'h00);
        check("t2_ce",    {24'h0, ce_v},   32'h0F);
        check("t2_ready", {24'h0, rdy_v},  32'h10);
        check("t2_busy",  {24'h0, busy_v}, 32'h1F);
        check("t2_rdata_kept", {16'h0, rdata}, 32'hBEEF);
        check("t2_mem",   {16'h0, mem[16'h00FF]}, 32'hA5A5);
        access(1'b0, 2'b11, 16'h00FF, 16'h0000, 0, ce_v, oe_v, we_v, drv_v, rdy_v, busy_v, ub_v, lb_v, a1);
        check("t2_readback", {16'h0, rdata}, 32'hA5A5);

        // Low-byte write
        access(1'b1, 2'b01, 16'h0300, 16'h1234, 0, ce_v, oe_v, we_v, drv_v, rdy_v, busy_v, ub_v, lb_v, a1);
        check("t3_lb", {24'h0, lb_v}, 32'h0F);
        check("t3_ub", {24'h0, ub_v}, 32'h00);
        access(1'b0, 2'b11, 16'h0300, 16'h0000, 0, ce_v, oe_v, we_v, drv_v, rdy_v, busy_v, ub_v, lb_v, a1);
        check("t3_readback", {16'h0, rdata}, 32'hFF34);

        // req pulsed during a write must be ignored
        access(1'b1, 2'b11, 16'h0400, 16'h1111, 1, ce_v, oe_v, we_v, drv_v, rdy_v, busy_v, ub_v, lb_v, a1);
        check("t4_ready",  {24'h0, rdy_v},  32'h10);
        check("t4_busy",   {24'h0, busy_v}, 32'h1F);
        check("t4_drive",  {24'h0, drv_v},  32'h0F);
        check("t4_mem",    {16'h0, mem[16'h0400]}, 32'h1111);
        check("t4_no_2nd", {16'h0, mem[16'h0500]}, 32'h0000);

        // Reset in the middle of the write pulse
        @(posedge Clk); #1;
        req = 1'b1; wr = 1'b1; be = 2'b11; addr = 16'h0700; wdata = 16'h7777;
        @(posedge Clk); #1;
        req = 1'b0;
        @(posedge Clk); #3;
        check("t5_we_pre", {31'h0, we_n}, 32'h0);
        Reset = 1'b1;
        #1;
        check("t5_we",     {31'h0, we_n}, 32'h1);
        check("t5_ce",     {31'h0, ce_n}, 32'h1);
        check("t5_data_z", {31'h0, (sram_data === 16'hzzzz)}, 32'h1);
        check("t5_busy",   {31'h0, busy}, 32'h0);
        check("t5_state",  {29'h0, dbg_state}, {29'h0, IDLE});
        rdy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (ready) rdy_seen++;
            if (k == 2) Reset = 1'b0;
        end
        check("t5_no_ready", rdy_seen, 0);
        check("t5_addr",     {12'h0, sram_addr}, 32'h0);

        // req held high: read then write, back to back
        @(posedge Clk); #1;
        req = 1'b1; wr = 1'b0; be = 2'b11; addr = 16'h1234; wdata = 16'h0000;
        @(posedge Clk); #1;
        wr = 1'b1; addr = 16'h0600; wdata = 16'h5A5A;
        overlap = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) req = 1'b0;
            @(negedge Clk);
            busy12[k] = busy;
            rdy12[k]  = ready;
            if (!oe_n && $isunknown(sram_data)) overlap++;
            @(posedge Clk); #1;
        end
        check("t6_busy",    {20'h0, busy12}, 32'h1F7);
        check("t6_ready",   {20'h0, rdy12},  32'h104);
        check("t6_overlap", overlap, 0);
        check("t6_rdata",   {16'h0, rdata}, 32'hBEEF);
        check("t6_mem",     {16'h0, mem[16'h0600]}, 32'h5A5A);
        check("t6_idle",    {27'h0, ce_n, ub_n, lb_n, oe_n, we_n}, {27'h0, SRAM_IDLE_CTL});
        check("t6_addr_hold", {12'h0, sram_addr}, 32'h00600);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
